seq_addsub_unit: RTL and testbench

//  Parametrised multi-cycle two's-complement adder/subtractor; successor to the

---
 rtl/seq_addsub_unit_pkg.sv | 14 +
 rtl/seq_addsub_unit_chunk_adder.sv | 28 ++
 rtl/seq_addsub_unit.sv | 113 +++++++++++
 tb/tb_seq_addsub_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_addsub_unit_pkg.sv
// Shared definitions for the sequential add/sub unit: FSM state encoding and
// mode constants used by the top and its consumers.
package seq_addsub_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/seq_addsub_unit_chunk_adder.sv
// Combinational CHUNK-bit ripple full-adder chain; also exposes the carry into
// its MSB so the top can derive signed overflow on the final chunk.
module chunk_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             c_o,
  output logic             cMsb_o
);

  logic carry;

  always_comb begin
    carry  = c_i;
    sum_o  = '0;
    cMsb_o = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) cMsb_o = carry;
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    c_o = carry;
  end

endmodule

// File: rtl/seq_addsub_unit.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per clock with a
// registered carry, valid/ready handshake on operand and result sides.
module seq_addsub_unit
  import seq_addsub_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             v,
  output logic             z
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_e           state_q;
  logic [WIDTH-1:0] opA_q;
  logic [WIDTH-1:0] opB_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             carry_q;
  logic             cOut_q;
  logic             v_q;
  logic             z_q;
  logic             outValid_q;
  logic [IDXW-1:0]  idx_q;

  logic [CHUNK-1:0] chunkSum;
  logic             chunkCout;
  logic             chunkCmsb;

  chunk_adder #(.CHUNK(CHUNK)) uChunk (
    .a_i    (opA_q[idx_q*CHUNK +: CHUNK]),
    .b_i    (opB_q[idx_q*CHUNK +: CHUNK]),
    .c_i    (carry_q),
    .sum_o  (chunkSum),
    .c_o    (chunkCout),
    .cMsb_o (chunkCmsb)
  );

  always_comb begin
    sum_d = sum_q;
    sum_d[idx_q*CHUNK +: CHUNK] = chunkSum;
  end

  // Subtraction is folded in at accept time: B is inverted and the carry
  // chain is seeded with 1, so BUSY only ever adds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      cOut_q     <= 1'b0;
      v_q        <= 1'b0;
      z_q        <= 1'b0;
      outValid_q <= 1'b0;
      idx_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opA_q   <= a;
            opB_q   <= b ^ {WIDTH{m}};
            carry_q <= (m == MODE_SUB);
            idx_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          sum_q   <= sum_d;
          carry_q <= chunkCout;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            cOut_q     <= chunkCout;
            v_q        <= chunkCmsb ^ chunkCout;
            z_q        <= (sum_d == '0);
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = outValid_q;
  assign s         = sum_q;
  assign c_out     = cOut_q;
  assign v         = v_q;
  assign z         = z_q;

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Self-checking bench for seq_addsub_unit: a CHUNK=2 instance for directed,
// table and random checks, and a CHUNK=8 instance for the wide sweep.
module tb_seq_addsub_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       inValidA, inReadyA, mA, outValidA, outReadyA, cA, vA, zA;
  logic [7:0] aA, bA, sA;
  logic       inValidW, inReadyW, mW, outValidW, outReadyW, cW, vW, zW;
  logic [7:0] aW, bW, sW;

  int checks   = 0;
  int failures = 0;

  seq_addsub_unit #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValidA), .in_ready(inReadyA),
    .a(aA), .b(bA), .m(mA), .out_valid(outValidA), .out_ready(outReadyA),
    .s(sA), .c_out(cA), .v(vA), .z(zA)
  );

  seq_addsub_unit #(.WIDTH(8), .CHUNK(8)) dutWide (
    .clk(clk), .rst_n(rst_n), .in_valid(inValidW), .in_ready(inReadyW),
    .a(aW), .b(bW), .m(mW), .out_valid(outValidW), .out_ready(outReadyW),
    .s(sW), .c_out(cW), .v(vW), .z(zW)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       m;
    logic [7:0] s;
    logic       c;
    logic       v;
    logic       z;
  } vec_t;

  vec_t vecs[6];

  // Reference: plain integer arithmetic, result packed as {s, c_out, v, z}.
  function automatic logic [10:0] model(input logic [7:0] aa, input logic [7:0] bb, input logic mm);
    int ua, ub, sa, sb, r, res;
    logic [7:0] sr;
    logic cr, vr, zr;
    ua = int'(aa);
    ub = int'(bb);
    sa = int'($signed(aa));
    sb = int'($signed(bb));
    if (mm) begin
      r   = ua - ub;
      res = sa - sb;
      cr  = (ua >= ub);
    end else begin
      r   = ua + ub;
      res = sa + sb;
      cr  = (r > 255);
    end
    sr = r[7:0];
    vr = (res > 127) || (res < -128);
    zr = (sr == 8'd0);
    return {sr, cr, vr, zr};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit wide, input logic [7:0] aa, input logic [7:0] bb,
                               input logic mm, output logic [10:0] res, output int lat);
    int n;
    @(negedge clk);
    if (wide) begin
      checkOutput("in_ready_wide", 32'(inReadyW), 32'd1);
      aW = aa; bW = bb; mW = mm; inValidW = 1'b1;
    end else begin
      checkOutput("in_ready", 32'(inReadyA), 32'd1);
      aA = aa; bA = bb; mA = mm; inValidA = 1'b1;
    end
    @(posedge clk); #1;
    inValidA = 1'b0;
    inValidW = 1'b0;
    n = 0;
    while (!(wide ? outValidW : outValidA) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n;
    res = wide ? {sW, cW, vW, zW} : {sA, cA, vA, zA};
    if (wide) outReadyW = 1'b1;
    else      outReadyA = 1'b1;
    @(posedge clk); #1;
    outReadyA = 1'b0;
    outReadyW = 1'b0;
  endtask

  initial begin
    logic [10:0] res;
    logic [10:0] exp;
    logic [7:0]  ra, rb;
    logic        rm;
    logic [7:0]  heldS;
    int          lat, n;

    vecs[0] = '{a: 8'd100, b: 8'd27, m: 1'b0, s: 8'd127, c: 1'b0, v: 1'b0, z: 1'b0};
    vecs[1] = '{a: 8'd100, b: 8'd28, m: 1'b0, s: 8'h80,  c: 1'b0, v: 1'b1, z: 1'b0};
    vecs[2] = '{a: 8'hFF,  b: 8'h01, m: 1'b0, s: 8'h00,  c: 1'b1, v: 1'b0, z: 1'b1};
    vecs[3] = '{a: 8'd5,   b: 8'd5,  m: 1'b1, s: 8'h00,  c: 1'b1, v: 1'b0, z: 1'b1};
    vecs[4] = '{a: 8'h80,  b: 8'h01, m: 1'b1, s: 8'h7F,  c: 1'b1, v: 1'b1, z: 1'b0};
    vecs[5] = '{a: 8'd3,   b: 8'd5,  m: 1'b1, s: 8'hFE,  c: 1'b0, v: 1'b0, z: 1'b0};

    rst_n = 1'b0;
    inValidA = 1'b0; aA = '0; bA = '0; mA = 1'b0; outReadyA = 1'b0;
    inValidW = 1'b0; aW = '0; bW = '0; mW = 1'b0; outReadyW = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(outValidA), 32'd0);
    checkOutput("reset_flags", 32'({sA, cA, vA, zA}), 32'd0);
    checkOutput("reset_in_ready", 32'(inReadyA), 32'd1);
    checkOutput("reset_wide_out_valid", 32'(outValidW), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors from the table
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, vecs[i].a, vecs[i].b, vecs[i].m, res, lat);
      checkOutput($sformatf("vec%0d_result", i), 32'(res),
                  32'({vecs[i].s, vecs[i].c, vecs[i].v, vecs[i].z}));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
    end

    // Random operands against the model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rm = 1'($urandom);
      applyStimulus(1'b0, ra, rb, rm, res, lat);
      checkOutput($sformatf("rand%0d_%0h_%0h_m%0d", i, ra, rb, rm), 32'({4'(lat), res}),
                  32'({4'd4, model(ra, rb, rm)}));
    end

    // Operand changes during BUSY, then stall in DONE
    @(negedge clk);
    aA = 8'd100; bA = 8'd27; mA = 1'b0; inValidA = 1'b1;
    @(posedge clk); #1;
    inValidA = 1'b0; aA = 8'hAA; bA = 8'h55; mA = 1'b1;
    n = 0;
    while (!outValidA && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("busy_change_latency", 32'(n), 32'd4);
    heldS = sA;
    checkOutput("busy_change_result", 32'({sA, cA, vA, zA}), 32'({8'd127, 3'b000}));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("stall%0d_valid_ready", k), 32'({outValidA, inReadyA}), 32'b10);
      checkOutput($sformatf("stall%0d_s", k), 32'(sA), 32'(heldS));
    end
    outReadyA = 1'b1;
    @(posedge clk); #1;
    outReadyA = 1'b0;
    checkOutput("release_valid_ready", 32'({outValidA, inReadyA}), 32'b01);

    // in_valid held high: second op accepted on the first IDLE cycle
    @(negedge clk);
    aA = 8'd10; bA = 8'd20; mA = 1'b0; inValidA = 1'b1;
    @(posedge clk); #1;
    aA = 8'd50; bA = 8'd7; mA = 1'b1;
    n = 0;
    while (!outValidA && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("held_first_s", 32'(sA), 32'd30);
    outReadyA = 1'b1;
    @(posedge clk); #1;
    outReadyA = 1'b0;
    n = 0;
    while (!outValidA && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    inValidA = 1'b0;
    checkOutput("held_second_gap", 32'(n), 32'd5);
    checkOutput("held_second_s", 32'(sA), 32'd43);
    outReadyA = 1'b1;
    @(posedge clk); #1;
    outReadyA = 1'b0;

    // Reset in the second BUSY cycle discards the op
    @(negedge clk);
    aA = 8'd100; bA = 8'd28; mA = 1'b0; inValidA = 1'b1;
    @(posedge clk); #1;
    inValidA = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midreset_in_ready", 32'(inReadyA), 32'd1);
    checkOutput("midreset_outputs", 32'({outValidA, sA, cA, vA, zA}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midreset_no_result", 32'(outValidA), 32'd0);

    // CHUNK=8 instance: all a against a spread of b, both modes, latency 1
    for (int ia = 0; ia < 256; ia++) begin
      for (int k = 0; k < 16; k++) begin
        for (int im = 0; im < 2; im++) begin
          ra = 8'(ia);
          rb = 8'(k * 17);
          rm = 1'(im);
          exp = model(ra, rb, rm);
          applyStimulus(1'b1, ra, rb, rm, res, lat);
          checkOutput($sformatf("wide_%0h_%0h_m%0d", ra, rb, rm), 32'({4'(lat), res}),
                      32'({4'd1, exp}));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
